// File: rtl/wr_arb_if.sv
// DDR write-channel handshake between the write arbiter (master) and the DDR controller (slave).
interface wr_arb_if;
    logic ddr_wreq;
    logic ddr_wrdy;
    logic ddr_wdone;
    logic ddr_wdata_req;

    modport master (
        output ddr_wreq,
        input  ddr_wrdy,
        input  ddr_wdone,
        input  ddr_wdata_req
    );

    modport slave (
        input  ddr_wreq,
        output ddr_wrdy,
        output ddr_wdone,
        output ddr_wdata_req
    );
endinterface

// File: rtl/wr_arb.sv
// Round-robin arbiter sharing the DDR write channel between two wr_cell writers,
// with burst-level handshake steering and a watchdog that frees a stuck channel.
module wr_arb #(
    parameter int unsigned           TO_WIDTH = 16,
    parameter logic [TO_WIDTH-1:0]   TIMEOUT  = TO_WIDTH'(4095)
) (
    input  logic          ddr_clk,
    input  logic          ddr_rst,
    wr_arb_if.master      ddr,
    input  logic          ddr_wreq1,
    input  logic          ddr_wreq2,
    output logic          ddr_wdata_req1,
    output logic          ddr_wdata_req2,
    output logic          ddr_wdone1,
    output logic          ddr_wdone2,
    output logic          wr_opera_en_2,
    output logic          arb_busy,
    output logic          arb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [TO_WIDTH-1:0] WD_LAST = TIMEOUT - TO_WIDTH'(1);

    state_t              state;
    logic                sel;
    logic                last;
    logic [TO_WIDTH-1:0] wd_cnt;

    logic wd_expire;
    logic done_ok;
    logic strobe_ok;

    // A completing wdone takes precedence over the watchdog in the same cycle.
    assign wd_expire = (state == DATA) && (wd_cnt == WD_LAST) && !ddr.ddr_wdone;
    // Done is honoured in DATA, or in REQ when it arrives together with wrdy.
    assign done_ok   = ddr.ddr_wdone &&
                       ((state == DATA) || ((state == REQ) && ddr.ddr_wrdy));
    assign strobe_ok = ddr.ddr_wdata_req && ((state == REQ) || (state == DATA));

    assign ddr.ddr_wreq   = (state == REQ);
    assign arb_busy       = (state != IDLE);
    assign arb_err        = wd_expire;
    assign wr_opera_en_2  = sel;
    assign ddr_wdata_req1 = strobe_ok && !sel;
    assign ddr_wdata_req2 = strobe_ok &&  sel;
    assign ddr_wdone1     = done_ok   && !sel;
    assign ddr_wdone2     = done_ok   &&  sel;

    // Scheduler state, grant select, fairness memory and watchdog counter.
    always_ff @(posedge ddr_clk) begin
        if (ddr_rst) begin
            state  <= IDLE;
            sel    <= 1'b0;
            last   <= 1'b1;
            wd_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ddr_wreq1 || ddr_wreq2) begin
                        sel   <= (ddr_wreq1 && ddr_wreq2) ? !last : ddr_wreq2;
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (ddr.ddr_wrdy) begin
                        if (ddr.ddr_wdone) begin
                            last  <= sel;
                            state <= GAP;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    wd_cnt <= wd_cnt + TO_WIDTH'(1);
                    if (ddr.ddr_wdone || wd_expire) begin
                        last  <= sel;
                        state <= GAP;
                    end
                end
                GAP: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wr_arb.sv
// Directed self-checking bench for wr_arb (watchdog shortened to 8 cycles).
module tb_wr_arb;

    logic ddr_clk;
    logic ddr_rst;
    logic ddr_wreq1;
    logic ddr_wreq2;
    logic ddr_wdata_req1;
    logic ddr_wdata_req2;
    logic ddr_wdone1;
    logic ddr_wdone2;
    logic wr_opera_en_2;
    logic arb_busy;
    logic arb_err;

    wr_arb_if ddr ();

    wr_arb #(
        .TO_WIDTH (16),
        .TIMEOUT  (16'd8)
    ) dut (
        .ddr_clk        (ddr_clk),
        .ddr_rst        (ddr_rst),
        .ddr            (ddr),
        .ddr_wreq1      (ddr_wreq1),
        .ddr_wreq2      (ddr_wreq2),
        .ddr_wdata_req1 (ddr_wdata_req1),
        .ddr_wdata_req2 (ddr_wdata_req2),
        .ddr_wdone1     (ddr_wdone1),
        .ddr_wdone2     (ddr_wdone2),
        .wr_opera_en_2  (wr_opera_en_2),
        .arb_busy       (arb_busy),
        .arb_err        (arb_err)
    );

    // {wreq, sel, busy, err, wdata_req1, wdata_req2, wdone1, wdone2}
    logic [7:0] outs;
    assign outs = {ddr.ddr_wreq, wr_opera_en_2, arb_busy, arb_err,
                   ddr_wdata_req1, ddr_wdata_req2, ddr_wdone1, ddr_wdone2};

    int checks   = 0;
    int failures = 0;

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = !ddr_clk;

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic clear_inputs();
        ddr_wreq1         = 1'b0;
        ddr_wreq2         = 1'b0;
        ddr.ddr_wrdy      = 1'b0;
        ddr.ddr_wdone     = 1'b0;
        ddr.ddr_wdata_req = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        ddr_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want %b", outs, 8'b0000_0000);
        end
        ddr_rst = 1'b0;
        tick();
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL reset_idle: got %b want %b", outs, 8'b0000_0000);
        end
    endtask

    task automatic test_cell1_only();
        ddr_wreq1 = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b1010_0000) begin
            failures++;
            $display("FAIL c1_req: got %b want %b", outs, 8'b1010_0000);
        end
        ddr_wreq1    = 1'b0;
        ddr.ddr_wrdy = 1'b1;
        #1;
        checks++;
        if (outs !== 8'b1010_0000) begin
            failures++;
            $display("FAIL c1_req_hold: got %b want %b", outs, 8'b1010_0000);
        end
        tick();
        ddr.ddr_wrdy = 1'b0;
        checks++;
        if (outs !== 8'b0010_0000) begin
            failures++;
            $display("FAIL c1_data_wreq_drop: got %b want %b", outs, 8'b0010_0000);
        end
        for (int i = 0; i < 3; i++) begin
            ddr.ddr_wdata_req = 1'b1;
            #1;
            checks++;
            if (outs !== 8'b0010_1000) begin
                failures++;
                $display("FAIL c1_strobe%0d: got %b want %b", i, outs, 8'b0010_1000);
            end
            tick();
            ddr.ddr_wdata_req = 1'b0;
        end
        ddr.ddr_wdone = 1'b1;
        #1;
        checks++;
        if (outs !== 8'b0010_0010) begin
            failures++;
            $display("FAIL c1_done: got %b want %b", outs, 8'b0010_0010);
        end
        tick();
        ddr.ddr_wdone = 1'b0;
        checks++;
        if (outs !== 8'b0010_0000) begin
            failures++;
            $display("FAIL c1_gap: got %b want %b", outs, 8'b0010_0000);
        end
        tick();
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL c1_idle: got %b want %b", outs, 8'b0000_0000);
        end
    endtask

    task automatic test_alternate();
        logic       s;
        logic [7:0] exp;
        test_reset();
        ddr_wreq1 = 1'b1;
        ddr_wreq2 = 1'b1;
        for (int b = 0; b < 4; b++) begin
            s = (b % 2) == 1;
            tick();
            exp = {1'b1, s, 1'b1, 5'b0_0000};
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL alt_req%0d: got %b want %b", b, outs, exp);
            end
            ddr.ddr_wrdy = 1'b1;
            tick();
            ddr.ddr_wrdy  = 1'b0;
            ddr.ddr_wdone = 1'b1;
            #1;
            exp = {1'b0, s, 1'b1, 1'b0, 2'b00, !s, s};
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL alt_done%0d: got %b want %b", b, outs, exp);
            end
            tick();
            ddr.ddr_wdone = 1'b0;
            tick();
            exp = {1'b0, s, 6'b00_0000};
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL alt_idle%0d: got %b want %b", b, outs, exp);
            end
        end
        ddr_wreq1 = 1'b0;
        ddr_wreq2 = 1'b0;
        tick();
    endtask

    task automatic test_same_cycle_done();
        ddr_wreq2 = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b1110_0000) begin
            failures++;
            $display("FAIL sc_req: got %b want %b", outs, 8'b1110_0000);
        end
        ddr_wreq2     = 1'b0;
        ddr.ddr_wrdy  = 1'b1;
        ddr.ddr_wdone = 1'b1;
        #1;
        checks++;
        if (outs !== 8'b1110_0001) begin
            failures++;
            $display("FAIL sc_done2: got %b want %b", outs, 8'b1110_0001);
        end
        tick();
        ddr.ddr_wrdy  = 1'b0;
        ddr.ddr_wdone = 1'b0;
        checks++;
        if (outs !== 8'b0110_0000) begin
            failures++;
            $display("FAIL sc_gap: got %b want %b", outs, 8'b0110_0000);
        end
        tick();
        checks++;
        if (outs !== 8'b0100_0000) begin
            failures++;
            $display("FAIL sc_idle: got %b want %b", outs, 8'b0100_0000);
        end
        ddr_wreq1 = 1'b1;
        ddr_wreq2 = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b1010_0000) begin
            failures++;
            $display("FAIL sc_tie_to_c1: got %b want %b", outs, 8'b1010_0000);
        end
        ddr_wreq1    = 1'b0;
        ddr_wreq2    = 1'b0;
        ddr.ddr_wrdy = 1'b1;
        tick();
        ddr.ddr_wrdy  = 1'b0;
        ddr.ddr_wdone = 1'b1;
        tick();
        ddr.ddr_wdone = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        ddr_wreq1 = 1'b1;
        ddr_wreq2 = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b1110_0000) begin
            failures++;
            $display("FAIL to_req_c2: got %b want %b", outs, 8'b1110_0000);
        end
        ddr.ddr_wrdy = 1'b1;
        tick();
        ddr.ddr_wrdy = 1'b0;
        for (int k = 1; k < 8; k++) begin
            checks++;
            if (outs !== 8'b0110_0000) begin
                failures++;
                $display("FAIL to_data%0d: got %b want %b", k, outs, 8'b0110_0000);
            end
            tick();
        end
        checks++;
        if (outs !== 8'b0111_0000) begin
            failures++;
            $display("FAIL to_err: got %b want %b", outs, 8'b0111_0000);
        end
        tick();
        checks++;
        if (outs !== 8'b0110_0000) begin
            failures++;
            $display("FAIL to_gap: got %b want %b", outs, 8'b0110_0000);
        end
        tick();
        tick();
        checks++;
        if (outs !== 8'b1010_0000) begin
            failures++;
            $display("FAIL to_next_c1: got %b want %b", outs, 8'b1010_0000);
        end
        ddr_wreq1    = 1'b0;
        ddr_wreq2    = 1'b0;
        ddr.ddr_wrdy = 1'b1;
        tick();
        ddr.ddr_wrdy = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        ddr.ddr_wdata_req = 1'b1;
        #1;
        checks++;
        if (outs !== 8'b0010_1000) begin
            failures++;
            $display("FAIL rm_data: got %b want %b", outs, 8'b0010_1000);
        end
        ddr_rst = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL rm_reset: got %b want %b", outs, 8'b0000_0000);
        end
        ddr_rst           = 1'b0;
        ddr.ddr_wdata_req = 1'b0;
        ddr.ddr_wdone     = 1'b1;
        #1;
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL rm_late_done: got %b want %b", outs, 8'b0000_0000);
        end
        tick();
        ddr.ddr_wdone = 1'b0;
        ddr_wreq1     = 1'b1;
        ddr_wreq2     = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b1010_0000) begin
            failures++;
            $display("FAIL rm_last_reset: got %b want %b", outs, 8'b1010_0000);
        end
        test_reset();
    endtask

    task automatic test_spurious_idle();
        ddr.ddr_wdone     = 1'b1;
        ddr.ddr_wdata_req = 1'b1;
        ddr.ddr_wrdy      = 1'b1;
        #1;
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL sp_comb: got %b want %b", outs, 8'b0000_0000);
        end
        tick();
        tick();
        checks++;
        if (outs !== 8'b0000_0000) begin
            failures++;
            $display("FAIL sp_stay_idle: got %b want %b", outs, 8'b0000_0000);
        end
        clear_inputs();
        ddr_wreq2 = 1'b1;
        tick();
        checks++;
        if (outs !== 8'b1110_0000) begin
            failures++;
            $display("FAIL sp_then_req: got %b want %b", outs, 8'b1110_0000);
        end
        clear_inputs();
    endtask

    initial begin
        ddr_rst = 1'b1;
        clear_inputs();
        test_reset();
        test_cell1_only();
        test_alternate();
        test_same_cycle_done();
        test_timeout();
        test_reset_mid_burst();
        test_spurious_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
